// File: rtl/nv_ram_rws_fifo_rdctl.sv
// FIFO controller for an external nv_ram_rws RAM with registered read address.
// A 2-entry output buffer hides the one-cycle RAM read latency for full throughput.
module nv_ram_rws_fifo_rdctl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout,
  input  logic [31:0]   pwrbus_ram_pd_in,
  output logic [31:0]   pwrbus_ram_pd,
  output logic [AW:0]   fifo_cnt
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          inflight_q;
  logic [1:0]    buf_cnt_q, buf_cnt_d, shift_cnt_s;
  logic [DW-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic          push_s, pop_s;
  logic [2:0]    occ_s;

  assign wr_prdy = (ram_cnt_q != FULL_CNT);
  assign push_s  = wr_pvld & wr_prdy;
  assign rd_pvld = (buf_cnt_q != 2'd0);
  assign rd_pd   = buf0_q;
  assign pop_s   = rd_pvld & rd_prdy;

  // Words that will sit in the buffer next cycle; a new read may only be
  // issued if its data will still find a free slot when it arrives.
  assign occ_s  = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign ram_re = (ram_cnt_q != {(AW+1){1'b0}}) & (occ_s < 3'd2);

  assign ram_we = push_s;
  assign ram_wa = wr_ptr_q;
  assign ram_di = wr_pd;
  assign ram_ra = rd_ptr_q;

  assign ram_cnt_d = ram_cnt_q + (AW+1)'(push_s) - (AW+1)'(ram_re);
  assign fifo_cnt  = ram_cnt_q + (AW+1)'(inflight_q) + (AW+1)'(buf_cnt_q);

  assign pwrbus_ram_pd = pwrbus_ram_pd_in;

  // Output buffer next state: shift on pop, then append returning RAM data at the tail.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop_s) begin
      buf0_d      = buf1_q;
      shift_cnt_s = buf_cnt_q - 2'd1;
    end else begin
      shift_cnt_s = buf_cnt_q;
    end
    if (inflight_q) begin
      case (shift_cnt_s)
        2'd0:    buf0_d = ram_dout;
        2'd1:    buf1_d = ram_dout;
        default: buf1_d = buf1_q;
      endcase
      buf_cnt_d = shift_cnt_s + 2'd1;
    end else begin
      buf_cnt_d = shift_cnt_s;
    end
  end

  // Pointer, occupancy and buffer state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      ram_cnt_q  <= {(AW+1){1'b0}};
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      buf0_q     <= {DW{1'b0}};
      buf1_q     <= {DW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end
      if (ram_re) begin
        rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= ram_re;
      buf_cnt_q  <= buf_cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule

// File: tb/tb_nv_ram_rws_fifo_rdctl.sv
// Directed and randomized bench for nv_ram_rws_fifo_rdctl with a behavioural RAM
// and a word-order scoreboard.
module tb_nv_ram_rws_fifo_rdctl;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DW    = 64;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic [AW-1:0] ram_wa;
  logic          ram_we;
  logic [DW-1:0] ram_di;
  logic [AW-1:0] ram_ra;
  logic          ram_re;
  logic [DW-1:0] ram_dout;
  logic [31:0]   pwrbus_ram_pd_in;
  logic [31:0]   pwrbus_ram_pd;
  logic [AW:0]   fifo_cnt;

  always #5 clk = ~clk;

  nv_ram_rws_fifo_rdctl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_dout(ram_dout),
    .pwrbus_ram_pd_in(pwrbus_ram_pd_in), .pwrbus_ram_pd(pwrbus_ram_pd),
    .fifo_cnt(fifo_cnt)
  );

  // RAM with registered read: dout updates the cycle after re and holds otherwise.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ram_dout <= mem[ram_ra];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: samples just before each rising edge, when inputs are stable.
  logic [63:0] sb_q[$];
  int  outs   = 0;
  bit  mon_en = 1'b0;
  always @(negedge clk) begin
    logic pop;
    #4;
    pop = rd_pvld & rd_prdy;
    if (!rstn) begin
      sb_q.delete();
      outs = 0;
    end else if (mon_en) begin
      check_val("cnt_vs_model", 64'(fifo_cnt), 64'(sb_q.size()));
      check_val("cnt_le_66", 64'(fifo_cnt <= 7'd66), 64'd1);
      if (pop) begin
        check_val("pop_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) check_val("sb_data", rd_pd, sb_q.pop_front());
      end
      if (wr_pvld && wr_prdy) sb_q.push_back(wr_pd);
      outs = outs + int'(ram_re) - int'(pop);
      check_val("outstanding_le2", 64'(outs <= 2), 64'd1);
    end
  end

  initial begin
    int first, last, got, pushed, popped;
    rstn = 1'b0; wr_pvld = 1'b0; wr_pd = 64'd0; rd_prdy = 1'b0;
    pwrbus_ram_pd_in = 32'hDEAD_BEEF;
    @(negedge clk); @(negedge clk);
    rstn = 1'b1; #1;
    check_val("rst_rd_pvld", 64'(rd_pvld), 64'd0);
    check_val("rst_ram_re", 64'(ram_re), 64'd0);
    check_val("rst_ram_we", 64'(ram_we), 64'd0);
    check_val("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    check_val("rst_wr_prdy", 64'(wr_prdy), 64'd1);
    check_val("pwrbus", 64'(pwrbus_ram_pd), 64'hDEAD_BEEF);
    mon_en = 1'b1;

    // Reset in the middle of traffic, while a read is in flight.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); wr_pvld = 1'b1; wr_pd = 64'(100 + i);
    end
    @(negedge clk); rstn = 1'b0;
    @(negedge clk);
    @(negedge clk); rstn = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b1; #1;
    check_val("mid_rst_rd_pvld", 64'(rd_pvld), 64'd0);
    check_val("mid_rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    check_val("mid_rst_wr_prdy", 64'(wr_prdy), 64'd1);
    check_val("mid_rst_ram_re", 64'(ram_re), 64'd0);
    @(negedge clk); #1;
    check_val("mid_rst_stale", 64'(rd_pvld), 64'd0);

    // Single-word latency from an empty FIFO.
    @(negedge clk); wr_pvld = 1'b1; wr_pd = 64'hA5A5; #1;
    check_val("lat_we_t0", 64'(ram_we), 64'd1);
    check_val("lat_re_t0", 64'(ram_re), 64'd0);
    @(negedge clk); wr_pvld = 1'b0; #1;
    check_val("lat_re_t1", 64'(ram_re), 64'd1);
    check_val("lat_ra_t1", 64'(ram_ra), 64'd0);
    check_val("lat_cnt_t1", 64'(fifo_cnt), 64'd1);
    @(negedge clk); #1;
    check_val("lat_vld_t2", 64'(rd_pvld), 64'd0);
    check_val("lat_cnt_t2", 64'(fifo_cnt), 64'd1);
    @(negedge clk); #1;
    check_val("lat_vld_t3", 64'(rd_pvld), 64'd1);
    check_val("lat_pd_t3", rd_pd, 64'hA5A5);
    @(negedge clk); #1;
    check_val("lat_cnt_t4", 64'(fifo_cnt), 64'd0);
    check_val("lat_vld_t4", 64'(rd_pvld), 64'd0);

    // Fill to 66 words with the reader stalled.
    for (int i = 0; i < 66; i++) begin
      @(negedge clk); rd_prdy = 1'b0; wr_pvld = 1'b1; wr_pd = 64'(i); #1;
      check_val("fill_wr_prdy", 64'(wr_prdy), 64'd1);
    end
    @(negedge clk); wr_pd = 64'd999; #1;
    check_val("full_wr_prdy", 64'(wr_prdy), 64'd0);
    check_val("full_ram_we", 64'(ram_we), 64'd0);
    check_val("full_fifo_cnt", 64'(fifo_cnt), 64'd66);
    check_val("full_ram_re", 64'(ram_re), 64'd0);
    // Pop and push together while the RAM is full: push must be refused.
    @(negedge clk); rd_prdy = 1'b1; #1;
    check_val("popfull_wr_prdy", 64'(wr_prdy), 64'd0);
    check_val("popfull_ram_re", 64'(ram_re), 64'd1);
    check_val("drain_pd_0", rd_pd, 64'd0);
    @(negedge clk); wr_pvld = 1'b0; #1;
    check_val("popfull_next_prdy", 64'(wr_prdy), 64'd1);
    for (int i = 1; i < 66; i++) begin
      if (i > 1) begin
        @(negedge clk); #1;
      end
      check_val("drain_vld", 64'(rd_pvld), 64'd1);
      check_val("drain_pd", rd_pd, 64'(i));
    end
    @(negedge clk); #1;
    check_val("drain_end_vld", 64'(rd_pvld), 64'd0);
    check_val("drain_end_cnt", 64'(fifo_cnt), 64'd0);

    // Continuous streaming of 200 words with the reader always ready.
    first = -1; last = -1; got = 0;
    for (int c = 0; c < 230; c++) begin
      @(negedge clk); wr_pvld = (c < 200); wr_pd = 64'(1000 + c); rd_prdy = 1'b1; #1;
      if (rd_pvld) begin
        if (first < 0) first = c;
        last = c;
        check_val("stream_pd", rd_pd, 64'(1000 + got));
        got++;
      end
    end
    check_val("stream_count", 64'(got), 64'd200);
    check_val("stream_first", 64'(first), 64'd3);
    check_val("stream_span", 64'(last - first + 1), 64'd200);

    // Random valid/ready over 1000 words; scoreboard checks order each cycle.
    pushed = 0; popped = 0;
    for (int c = 0; c < 20000 && popped < 1000; c++) begin
      @(negedge clk);
      wr_pvld = (pushed < 1000) && ($urandom_range(1, 0) == 1);
      wr_pd   = {$urandom, $urandom};
      rd_prdy = ($urandom_range(1, 0) == 1);
      #1;
      if (wr_pvld && wr_prdy) pushed++;
      if (rd_pvld && rd_prdy) popped++;
    end
    check_val("rand_popped", 64'(popped), 64'd1000);
    @(negedge clk); wr_pvld = 1'b0; rd_prdy = 1'b0; #1;
    check_val("rand_end_cnt", 64'(fifo_cnt), 64'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
